// File: rtl/cdud_pkg.sv
// Shared constants and helpers for the BCD decade counter family.
package cdud_pkg;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] BCD_NINE    = 4'h9;
   localparam int         MAX_DIGITS  = 8;

   function automatic logic is_bcd_digit(input logic [3:0] d);
      return d <= BCD_NINE;
   endfunction

   // With legal digits, the packed-nibble binary order equals decimal order.
   // Illegal digits are flagged separately, so a plain unsigned compare is enough.
   function automatic logic bcd_gt(input logic [31:0] a, input logic [31:0] b);
      return a > b;
   endfunction

   // True when the low n digits of v are all legal BCD (used on MAXVAL).
   function automatic logic bcd_all_legal(input logic [31:0] v, input int n);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < MAX_DIGITS; i++)
         if (i < n && !is_bcd_digit(v[i*BCD_DIGIT_W +: BCD_DIGIT_W])) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the ripple chain: steps up/down when step_in is set
// and passes a carry/borrow to the next digit.
module bcd_digit_cell
   import cdud_pkg::*;
(
   input  logic [3:0] q,
   input  logic       dnup,
   input  logic       step_in,
   output logic [3:0] q_next,
   output logic       step_out
);

   // Next digit value and carry/borrow out.
   always_comb begin
      q_next   = q;
      step_out = step_in & (dnup ? (q == 4'd0) : (q == BCD_NINE));
      if (step_in) begin
         if (dnup) q_next = (q == 4'd0) ? BCD_NINE : q - 4'd1;
         else      q_next = (q == BCD_NINE) ? 4'd0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/cdud_bcd_n.sv
// N-digit BCD up/down counter with clear, load, cascade carry and
// programmable top count. TC is combinational for chaining into CI.
module cdud_bcd_n
   import cdud_pkg::*;
#(
   parameter int                    DIGITS = 2,
   parameter logic [4*DIGITS-1:0]   MAXVAL = {DIGITS{4'h9}}
) (
   input  logic                  CLK,
   input  logic                  CDN,
   input  logic                  CS,
   input  logic                  LD,
   input  logic [4*DIGITS-1:0]   D,
   input  logic                  EN,
   input  logic                  CI,
   input  logic                  DNUP,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  TC,
   output logic                  ERR
);

   localparam int W = BCD_DIGIT_W * DIGITS;

   // Reject an illegal digit count or a non-BCD top count at elaboration.
   if (DIGITS < 1 || DIGITS > MAX_DIGITS || !bcd_all_legal(32'(MAXVAL), DIGITS)) begin : g_bad_param
      $error("cdud_bcd_n: DIGITS out of range or MAXVAL holds a non-BCD digit");
   end

   logic [W-1:0]      r_q;
   logic [W-1:0]      w_chain;
   logic [W-1:0]      w_next;
   logic [DIGITS:0]   w_step;
   logic [DIGITS-1:0] w_dig_bad;
   logic              w_err;
   logic              w_wrap;
   logic              w_cnt_en;

   assign w_step[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_cell u_cell (
         .q        (r_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .dnup     (DNUP),
         .step_in  (w_step[g]),
         .q_next   (w_chain[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .step_out (w_step[g+1])
      );
      assign w_dig_bad[g] = !is_bcd_digit(r_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]);
   end

   assign w_err = (|w_dig_bad) | bcd_gt(32'(r_q), 32'(MAXVAL));

   // Borrow out of the top digit while counting down means every digit is 0.
   assign w_wrap   = DNUP ? w_step[DIGITS] : (r_q == MAXVAL);
   assign w_next   = w_wrap ? (DNUP ? MAXVAL : '0) : w_chain;
   assign w_cnt_en = EN & CI & ~w_err;

   // Count register: reset > clear > load > count > hold.
   always_ff @(posedge CLK) begin
      if (!CDN)          r_q <= '0;
      else if (CS)       r_q <= '0;
      else if (LD)       r_q <= D;
      else if (w_cnt_en) r_q <= w_next;
   end

   assign Q   = r_q;
   assign ERR = w_err;
   assign TC  = w_cnt_en & w_wrap;

endmodule

// File: tb/tb_cdud_bcd_n.sv
// Directed self-checking bench for cdud_bcd_n.
module tb_cdud_bcd_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // main instance: 2 digits, top 99
   logic       cdn, cs, ld, en, ci, dnup;
   logic [7:0] d, q;
   logic       tc, err;
   // top-59 instance
   logic       m_ld, m_en, m_dnup;
   logic [7:0] m_d, m_q;
   logic       m_tc, m_err;
   // cascade pair
   logic       c_en, lo_ld, hi_ld;
   logic [7:0] lo_d, hi_d, lo_q, hi_q;
   logic       lo_tc, lo_err, hi_tc, hi_err;

   cdud_bcd_n #(.DIGITS(2), .MAXVAL(8'h99)) dut (
      .CLK(clk), .CDN(cdn), .CS(cs), .LD(ld), .D(d), .EN(en), .CI(ci), .DNUP(dnup),
      .Q(q), .TC(tc), .ERR(err));

   cdud_bcd_n #(.DIGITS(2), .MAXVAL(8'h59)) u59 (
      .CLK(clk), .CDN(cdn), .CS(1'b0), .LD(m_ld), .D(m_d), .EN(m_en), .CI(1'b1), .DNUP(m_dnup),
      .Q(m_q), .TC(m_tc), .ERR(m_err));

   cdud_bcd_n #(.DIGITS(2)) u_lo (
      .CLK(clk), .CDN(cdn), .CS(1'b0), .LD(lo_ld), .D(lo_d), .EN(c_en), .CI(1'b1), .DNUP(1'b0),
      .Q(lo_q), .TC(lo_tc), .ERR(lo_err));

   cdud_bcd_n #(.DIGITS(2)) u_hi (
      .CLK(clk), .CDN(cdn), .CS(1'b0), .LD(hi_ld), .D(hi_d), .EN(c_en), .CI(lo_tc), .DNUP(1'b0),
      .Q(hi_q), .TC(hi_tc), .ERR(hi_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] to_bcd4(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   int          cnt;
   logic        prev_lo_tc;
   logic [7:0]  prev_hi;

   initial begin
      cdn = 1'b0; cs = 1'b0; ld = 1'b0; d = 8'h00; en = 1'b0; ci = 1'b1; dnup = 1'b0;
      m_ld = 1'b0; m_d = 8'h00; m_en = 1'b0; m_dnup = 1'b0;
      c_en = 1'b0; lo_ld = 1'b0; hi_ld = 1'b0; lo_d = 8'h00; hi_d = 8'h00;
      #1;
      tick();

      // 1: reset beats load
      cdn = 1'b1; ld = 1'b1; d = 8'h57; tick();
      chk("load57", 32'(q), 32'h57);
      cdn = 1'b0; ld = 1'b1; d = 8'h33; en = 1'b1; tick();
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_err", 32'(err), 32'h0);
      dnup = 1'b0; #1;
      chk("rst_tc_up", 32'(tc), 32'h0);
      dnup = 1'b1; #1;
      chk("rst_tc_dn", 32'(tc), 32'h1);
      cdn = 1'b1; ld = 1'b0; dnup = 1'b0;

      // 2: up count with digit carry and wrap
      ld = 1'b1; d = 8'h08; tick(); ld = 1'b0;
      chk("ld08", 32'(q), 32'h08);
      tick(); chk("up09", 32'(q), 32'h09);
      chk("tc09", 32'(tc), 32'h0);
      tick(); chk("up10", 32'(q), 32'h10);
      ld = 1'b1; d = 8'h98; tick(); ld = 1'b0;
      tick(); chk("up99", 32'(q), 32'h99);
      chk("tc99", 32'(tc), 32'h1);
      tick(); chk("wrap00", 32'(q), 32'h00);
      chk("tc00_up", 32'(tc), 32'h0);

      // 3: down count, wrap and borrow
      dnup = 1'b1; #1;
      chk("tc00_dn", 32'(tc), 32'h1);
      tick(); chk("dn99", 32'(q), 32'h99);
      ld = 1'b1; d = 8'h10; tick(); ld = 1'b0;
      tick(); chk("dn09", 32'(q), 32'h09);
      dnup = 1'b0; tick(); chk("dir_up10", 32'(q), 32'h10);

      // CI=0 holds and blocks TC
      ld = 1'b1; d = 8'h99; tick(); ld = 1'b0;
      ci = 1'b0; #1;
      chk("ci0_tc", 32'(tc), 32'h0);
      tick(); chk("ci0_hold", 32'(q), 32'h99);
      ci = 1'b1;
      // load wins over count
      ld = 1'b1; d = 8'h45; tick(); ld = 1'b0;
      chk("ld_over_cnt", 32'(q), 32'h45);

      // 5: illegal load, hold, clear
      ld = 1'b1; d = 8'h3C; tick(); ld = 1'b0;
      chk("ld3C", 32'(q), 32'h3C);
      chk("err3C", 32'(err), 32'h1);
      chk("tc3C", 32'(tc), 32'h0);
      tick(); chk("hold3C", 32'(q), 32'h3C);
      cs = 1'b1; tick(); cs = 1'b0;
      chk("cs_q", 32'(q), 32'h00);
      chk("cs_err", 32'(err), 32'h0);
      en = 1'b0;

      // 4: top count 59
      m_ld = 1'b1; m_d = 8'h58; tick(); m_ld = 1'b0; m_en = 1'b1;
      chk("m_tc58", 32'(m_tc), 32'h0);
      tick(); chk("m_up59", 32'(m_q), 32'h59);
      chk("m_tc59", 32'(m_tc), 32'h1);
      tick(); chk("m_wrap00", 32'(m_q), 32'h00);
      m_dnup = 1'b1; #1;
      chk("m_tc00_dn", 32'(m_tc), 32'h1);
      tick(); chk("m_dn59", 32'(m_q), 32'h59);
      m_en = 1'b0; m_ld = 1'b1; m_d = 8'h60; tick(); m_ld = 1'b0;
      chk("m_err60", 32'(m_err), 32'h1);
      m_en = 1'b1; tick();
      chk("m_hold60", 32'(m_q), 32'h60);
      m_en = 1'b0;

      // 6: cascade from 0099 for 100 edges
      lo_ld = 1'b1; lo_d = 8'h99; hi_ld = 1'b1; hi_d = 8'h00; tick();
      lo_ld = 1'b0; hi_ld = 1'b0;
      c_en = 1'b1;
      cnt = 99;
      for (int i = 0; i < 100; i++) begin
         #1;
         prev_lo_tc = lo_tc;
         prev_hi    = hi_q;
         tick();
         cnt = (cnt + 1) % 10000;
         chk("casc_val", 32'({hi_q, lo_q}), 32'(to_bcd4(cnt)));
         chk("casc_hi_step", 32'(hi_q != prev_hi), 32'(prev_lo_tc));
      end
      c_en = 1'b0;
      chk("casc_final", 32'({hi_q, lo_q}), 32'h0199);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
